tl_timed_ctrl: RTL and testbench
================================

Name: tl_timed_ctrl

Overview:
Timed traffic-light controller for a two-street intersection (street A, street B) with a pedestrian phase. It sequences green/yellow/red for both streets from the traffic sensors Ta/Tb. It enforces a minimum green time and a fixed yellow time, and inserts an all-red walk phase when a pedestrian request is pending. It is the sequencing layer above the two-bit next-state logic and drives the lamp drivers directly.

Parameters:
MIN_GRN, 10, minimum green duration in clock cycles (>=1)
YEL_CYC, 5, yellow duration in clock cycles (>=1)
PED_CYC, 8, walk-phase duration in clock cycles (>=1)
CNT_W, 4, phase timer width; must hold max(MIN_GRN, YEL_CYC, PED_CYC)-1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
Ta  input  1  1 = traffic present on street A
Tb  input  1  1 = traffic present on street B
ped_req  input  1  pedestrian button, level-sampled every cycle
La  output  2  street A lamp: 00 green, 01 yellow, 10 red
Lb  output  2  street B lamp, same encoding as La
walk  output  1  pedestrian walk lamp
state  output  3  current state, debug/observation

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset: state=S_GA, timer=0, ped_pending=0, La=00, Lb=10, walk=0. Reset wins over all other inputs in any state, including mid-yellow or mid-walk.
- States: S_GA=0 (A green, B red), S_YA=1 (A yellow, B red), S_GB=2 (A red, B green), S_YB=3 (A red, B yellow), S_PED=4 (both red, walk=1). Codes 5-7 are illegal and go to S_GA on the next edge.
- Outputs are a Moore decode of the state register; no combinational path from inputs to outputs.
- Phase timer: clears to 0 on every state change and increments by 1 otherwise. It saturates at 2^CNT_W-1 and never wraps.
- grn_done = (timer >= MIN_GRN-1).
- S_GA -> S_YA when grn_done and (!Ta or ped_pending). Otherwise stay.
- S_YA: leaves when timer == YEL_CYC-1, so yellow lasts exactly YEL_CYC cycles. Goes to S_PED if ped_pending, else S_GB.
- S_GB -> S_YB when grn_done and (!Tb or ped_pending).
- S_YB: leaves when timer == YEL_CYC-1. Goes to S_PED if ped_pending, else S_GA.
- S_PED: lasts exactly PED_CYC cycles. Exits to the green of the street opposite the one that just went yellow: after S_YA go to S_GB, after S_YB go to S_GA. A one-bit last_dir register, written on yellow exit, records which street that was.
- ped_pending:
  - Set on any cycle with ped_req=1 outside S_PED.
  - Cleared on the edge that enters S_PED.
  - ped_req during S_PED is ignored.
  - If set and clear coincide on the same edge, clear wins.
- Ta=Tb=1 with no pedestrian request: the current green holds indefinitely (no starvation timeout in this block).
- Ta=Tb=0: phases alternate, each green lasting MIN_GRN cycles.

Decomposition:
- Shared package tl_pkg: state codes (S_GA..S_PED), lamp encodings (L_GREEN=00, L_YELLOW=01, L_RED=10), state width constant.
- One sub-module, tl_phase_timer: a CNT_W-bit counter with synchronous clear, enable and saturation. It is instantiated once and driven by the state-change strobe.

Test Plan:
- Reset: hold reset 3 cycles, then release with Ta=1 -> La=00, Lb=10, walk=0, state=0, and this holds for 50 cycles.
- Ta=0, Tb=1 from release (cycle 0):
  - Cycles 0-9: S_GA.
  - Cycles 10-14: S_YA (La=01).
  - Cycle 15 onward: S_GB (La=10, Lb=00), held while Tb=1.
- Pedestrian: Ta=1, one-cycle ped_req at cycle 3:
  - Cycle 10: S_YA.
  - Cycles 15-22: S_PED with walk=1, La=Lb=10.
  - Cycle 23: S_GB.
  - ped_req pulsed at cycle 18 is ignored, so no second walk phase follows.
- Alternation with Ta=Tb=0: states follow GA(10) YA(5) GB(10) YB(5) GA with exact cycle counts. After a walk entered from S_YB, the next state is S_GA.
- Reset mid-operation: assert reset at cycle 12 (in S_YA) with ped_pending set -> next edge gives S_GA, timer=0, ped_pending=0, and no walk phase follows.
- Saturation/illegal state: set MIN_GRN=3 with Ta=1 for 40 cycles, then drop Ta -> timer stays at 15 (no wrap) and S_YA is entered on the next edge. Forcing state=6 -> S_GA on the next edge.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared definitions for the timed traffic-light controller: state codes,
// lamp encodings and the state width.
package tl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_GA  = 3'd0,
        S_YA  = 3'd1,
        S_GB  = 3'd2,
        S_YB  = 3'd3,
        S_PED = 3'd4
    } state_t;

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b10;

    // Last street that went yellow, used to pick the green after a walk
    localparam logic DIR_A = 1'b0;
    localparam logic DIR_B = 1'b1;

endpackage

// File: rtl/tl_timed_ctrl_if.sv
// Sensor/button inputs and lamp/observation outputs of the intersection controller.
interface tl_timed_ctrl_if;
    logic                       Ta;
    logic                       Tb;
    logic                       ped_req;
    logic [1:0]                 La;
    logic [1:0]                 Lb;
    logic                       walk;
    logic [tl_pkg::STATE_W-1:0] state;

    modport master (output Ta, Tb, ped_req, input La, Lb, walk, state);
    modport slave  (input Ta, Tb, ped_req, output La, Lb, walk, state);
endinterface

// File: rtl/tl_phase_timer.sv
// Phase timer: synchronous clear, count enable, saturates at all-ones.
module tl_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (en && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/tl_timed_ctrl.sv
// Two-street traffic-light sequencer with minimum green, fixed yellow and an
// all-red pedestrian walk phase; lamps are a Moore decode of the state register.
module tl_timed_ctrl
    import tl_pkg::*;
#(
    parameter int MIN_GRN = 10,
    parameter int YEL_CYC = 5,
    parameter int PED_CYC = 8,
    parameter int CNT_W   = 4
) (
    input  logic           clk,
    input  logic           reset,
    tl_timed_ctrl_if.slave bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer;
    logic             ped_pending;
    logic             last_dir;
    logic             grn_done, yel_done, ped_done, state_chg;

    assign grn_done  = (timer >= CNT_W'(MIN_GRN - 1));
    assign yel_done  = (timer == CNT_W'(YEL_CYC - 1));
    assign ped_done  = (timer == CNT_W'(PED_CYC - 1));
    assign state_chg = (state_d != state_q);

    tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (state_chg),
        .en    (1'b1),
        .cnt   (timer)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_GA;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_GA:    if (grn_done && (!bus.Ta || ped_pending)) state_d = S_YA;
            S_YA:    if (yel_done) state_d = ped_pending ? S_PED : S_GB;
            S_GB:    if (grn_done && (!bus.Tb || ped_pending)) state_d = S_YB;
            S_YB:    if (yel_done) state_d = ped_pending ? S_PED : S_GA;
            S_PED:   if (ped_done) state_d = (last_dir == DIR_A) ? S_GB : S_GA;
            default: state_d = S_GA;
        endcase
    end

    // Clearing on walk entry takes priority over a same-cycle button press
    always_ff @(posedge clk) begin
        if (reset)
            ped_pending <= 1'b0;
        else if (state_d == S_PED && state_q != S_PED)
            ped_pending <= 1'b0;
        else if (bus.ped_req && state_q != S_PED)
            ped_pending <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            last_dir <= DIR_A;
        else if (state_q == S_YA && state_chg)
            last_dir <= DIR_A;
        else if (state_q == S_YB && state_chg)
            last_dir <= DIR_B;
    end

    always_comb begin
        bus.La   = L_RED;
        bus.Lb   = L_RED;
        bus.walk = 1'b0;
        case (state_q)
            S_GA:    bus.La = L_GREEN;
            S_YA:    bus.La = L_YELLOW;
            S_GB:    bus.Lb = L_GREEN;
            S_YB:    bus.Lb = L_YELLOW;
            S_PED:   bus.walk = 1'b1;
            default: ;
        endcase
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_tl_timed_ctrl.sv
// Directed and random checks of tl_timed_ctrl against a dwell-time model of the light sequence.
module tb_tl_timed_ctrl;
    import tl_pkg::*;

    localparam int MIN_GRN = 10;
    localparam int YEL_CYC = 5;
    localparam int PED_CYC = 8;

    logic clk = 1'b0;
    logic reset, reset2;
    int   total = 0;
    int   bad = 0;

    tl_timed_ctrl_if bus ();
    tl_timed_ctrl_if bus2 ();

    tl_timed_ctrl #(.MIN_GRN(MIN_GRN), .YEL_CYC(YEL_CYC), .PED_CYC(PED_CYC), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    tl_timed_ctrl #(.MIN_GRN(3), .YEL_CYC(YEL_CYC), .PED_CYC(PED_CYC), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset2), .bus(bus2)
    );

    always #5 clk = ~clk;

    // Model: phase 0..4 as in the lamp table, age = cycles spent in the phase (unbounded)
    int m_ph, m_age;
    bit m_pend, m_last;

    function automatic logic [7:0] lamps(input int ph);
        case (ph)
            0:       return {3'd0, 2'b00, 2'b10, 1'b0};
            1:       return {3'd1, 2'b01, 2'b10, 1'b0};
            2:       return {3'd2, 2'b10, 2'b00, 1'b0};
            3:       return {3'd3, 2'b10, 2'b01, 1'b0};
            default: return {3'd4, 2'b10, 2'b10, 1'b1};
        endcase
    endfunction

    task automatic model_step(input logic ta, input logic tb, input logic pr, input logic rs);
        int nph;
        bit nlast;
        if (rs) begin
            m_ph = 0; m_age = 0; m_pend = 0; m_last = 0;
            return;
        end
        nph = m_ph;
        nlast = m_last;
        case (m_ph)
            0: if (m_age >= MIN_GRN - 1 && (!ta || m_pend)) nph = 1;
            1: if (m_age == YEL_CYC - 1) begin nph = m_pend ? 4 : 2; nlast = 0; end
            2: if (m_age >= MIN_GRN - 1 && (!tb || m_pend)) nph = 3;
            3: if (m_age == YEL_CYC - 1) begin nph = m_pend ? 4 : 0; nlast = 1; end
            default: if (m_age == PED_CYC - 1) nph = m_last ? 0 : 2;
        endcase
        if (nph == 4 && m_ph != 4) m_pend = 0;
        else if (pr && m_ph != 4) m_pend = 1;
        m_age = (nph != m_ph) ? 0 : m_age + 1;
        m_ph = nph;
        m_last = nlast;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dut_obs();
        return {bus.state, bus.La, bus.Lb, bus.walk};
    endfunction

    // Apply inputs for one cycle, advance the model, then compare after the edge
    task automatic cyc(input logic ta, input logic tb, input logic pr, input logic rs);
        bus.Ta = ta; bus.Tb = tb; bus.ped_req = pr; reset = rs;
        model_step(ta, tb, pr, rs);
        @(negedge clk);
        chk("model", dut_obs(), lamps(m_ph));
    endtask

    task automatic do_reset();
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int walks;
        logic ta, tb, pr, rs;
        reset = 1'b1; reset2 = 1'b1;
        bus.Ta = 1'b1; bus.Tb = 1'b0; bus.ped_req = 1'b0;
        bus2.Ta = 1'b1; bus2.Tb = 1'b0; bus2.ped_req = 1'b0;
        m_ph = 0; m_age = 0; m_pend = 0; m_last = 0;
        @(negedge clk);

        // Reset then Ta held: A green forever
        do_reset();
        chk("reset_state", dut_obs(), {3'd0, 2'b00, 2'b10, 1'b0});
        for (int j = 1; j <= 50; j++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ta_hold", dut_obs(), {3'd0, 2'b00, 2'b10, 1'b0});

        // Ta=0, Tb=1: GA 0-9, YA 10-14, GB from 15
        do_reset();
        for (int j = 1; j <= 30; j++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            if (j == 9)  chk("ga_last", {5'd0, bus.state}, 8'd0);
            if (j == 10) chk("ya_first", {6'd0, bus.La}, 8'b01);
            if (j == 14) chk("ya_last", {5'd0, bus.state}, 8'd1);
            if (j == 15) chk("gb_first", {4'd0, bus.La, bus.Lb}, 8'b1000);
        end

        // Pedestrian at cycle 3 with Ta=1; press at 18 lands inside the walk
        do_reset();
        walks = 0;
        for (int j = 1; j <= 60; j++) begin
            cyc(1'b1, 1'b1, (j == 4 || j == 19), 1'b0);
            walks += int'(bus.walk);
            if (j == 10) chk("ped_ya", {5'd0, bus.state}, 8'd1);
            if (j == 15) chk("ped_walk_in", dut_obs(), {3'd4, 2'b10, 2'b10, 1'b1});
            if (j == 22) chk("ped_walk_end", {5'd0, bus.state}, 8'd4);
            if (j == 23) chk("ped_gb", {5'd0, bus.state}, 8'd2);
        end
        chk("ped_walk_count", 8'(walks), 8'd8);

        // Alternation with no traffic; walk after YB returns to GA
        do_reset();
        for (int j = 1; j <= 50; j++) begin
            cyc(1'b0, 1'b0, (j == 21), 1'b0);
            if (j == 25) chk("alt_yb", {5'd0, bus.state}, 8'd3);
            if (j == 30) chk("alt_walk", {5'd0, bus.state}, 8'd4);
            if (j == 38) chk("alt_ga_after_walk", {5'd0, bus.state}, 8'd0);
        end

        // Reset during yellow with a walk pending
        do_reset();
        for (int j = 1; j <= 12; j++) cyc(1'b1, 1'b0, (j == 4), 1'b0);
        chk("mid_ya", {6'd0, bus.La}, 8'b01);
        chk("mid_pend_set", {7'd0, dut.ped_pending}, 8'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_timer", {4'd0, dut.u_timer.cnt}, 8'd0);
        chk("mid_rst_pend", {7'd0, dut.ped_pending}, 8'd0);
        walks = 0;
        for (int j = 1; j <= 40; j++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            walks += int'(bus.walk);
        end
        chk("mid_no_walk", 8'(walks), 8'd0);

        // Random traffic, rare buttons and resets
        for (int i = 0; i < 800; i++) begin
            ta = ($urandom_range(0, 3) != 0);
            tb = ($urandom_range(0, 3) != 0);
            pr = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 199) == 0);
            cyc(ta, tb, pr, rs);
        end

        // Short-green instance: timer saturates, then leaves on Ta drop
        reset2 = 1'b0;
        for (int j = 0; j < 40; j++) @(negedge clk);
        chk("sat_timer", {4'd0, dut2.u_timer.cnt}, 8'd15);
        chk("sat_ga", {5'd0, bus2.state}, 8'd0);
        bus2.Ta = 1'b0;
        @(negedge clk);
        chk("sat_ya", {5'd0, bus2.state}, 8'd1);

        // Illegal code steers next state to GA
        force dut2.state_q = state_t'(3'd6);
        #1;
        chk("illegal_next", {5'd0, dut2.state_d}, 8'd0);
        @(negedge clk);
        release dut2.state_q;
        reset2 = 1'b1;
        @(negedge clk);
        chk("dut2_reset", {5'd0, bus2.state}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
